// File: rtl/coeff_inverse_scan.sv
// Inverse coefficient scan for a 16x16 block: accepts 256 coefficients in scan order
// (diagonal, horizontal or vertical) and replays them in raster order with flow control.
module coeff_inverse_scan #(
  parameter int unsigned COEFF_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [1:0]         scan_type,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [COEFF_W-1:0] in_coeff,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [COEFF_W-1:0] out_coeff,
  output logic [7:0]         out_pos,
  output logic               out_last,
  output logic               busy,
  output logic [7:0]         last_sig_scan,
  output logic               all_zero
);

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StDrain
  } state_e;

  localparam logic [1:0] ScanDiag  = 2'd0;
  localparam logic [1:0] ScanHoriz = 2'd1;
  localparam logic [1:0] ScanVert  = 2'd2;

  state_e state_q, state_d;

  logic [1:0] scan_q, scan_d;
  logic [7:0] k_q, k_d;
  logic [7:0] r_q, r_d;
  logic [3:0] row_q, row_d;
  logic [3:0] col_q, col_d;
  logic [4:0] diag_q, diag_d;
  logic [7:0] last_sig_q, last_sig_d;
  logic       all_zero_q, all_zero_d;

  logic [COEFF_W-1:0] mem_q [256];

  logic       in_hs;
  logic       out_hs;
  logic [7:0] wr_addr;

  // Diagonal walker: next (row, col, anti-diagonal) after the current scan position
  logic [3:0] row_step;
  logic [3:0] col_step;
  logic [4:0] diag_step;
  logic [4:0] diag_nx;
  logic [4:0] row_w;
  logic [4:0] col_w;

  assign in_hs  = in_valid & in_ready;
  assign out_hs = out_valid & out_ready;

  always_comb begin
    diag_nx   = diag_q + 5'd1;
    row_w     = '0;
    col_w     = '0;
    row_step  = row_q;
    col_step  = col_q;
    diag_step = diag_q;
    if (!diag_q[0]) begin
      // Even anti-diagonal: row descends until it hits row 0 or column 15
      if (row_q == 4'd0 || col_q == 4'd15) begin
        row_w     = (diag_nx > 5'd15) ? (diag_nx - 5'd15) : 5'd0;
        col_w     = diag_nx - row_w;
        row_step  = row_w[3:0];
        col_step  = col_w[3:0];
        diag_step = diag_nx;
      end else begin
        row_step = row_q - 4'd1;
        col_step = col_q + 4'd1;
      end
    end else begin
      // Odd anti-diagonal: row ascends until it hits row 15 or column 0
      if (row_q == 4'd15 || col_q == 4'd0) begin
        row_w     = (diag_nx > 5'd15) ? 5'd15 : diag_nx;
        col_w     = diag_nx - row_w;
        row_step  = row_w[3:0];
        col_step  = col_w[3:0];
        diag_step = diag_nx;
      end else begin
        row_step = row_q + 4'd1;
        col_step = col_q - 4'd1;
      end
    end
  end

  always_comb begin
    wr_addr = {row_q, col_q};
    unique case (scan_q)
      ScanHoriz: wr_addr = k_q;
      ScanVert:  wr_addr = {k_q[3:0], k_q[7:4]};
      default:   wr_addr = {row_q, col_q};
    endcase
  end

  always_comb begin
    state_d    = state_q;
    scan_d     = scan_q;
    k_d        = k_q;
    r_d        = r_q;
    row_d      = row_q;
    col_d      = col_q;
    diag_d     = diag_q;
    last_sig_d = last_sig_q;
    all_zero_d = all_zero_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d    = StLoad;
          scan_d     = (scan_type == 2'd3) ? ScanDiag : scan_type;
          k_d        = '0;
          r_d        = '0;
          row_d      = '0;
          col_d      = '0;
          diag_d     = '0;
          last_sig_d = '0;
          all_zero_d = 1'b1;
        end
      end
      StLoad: begin
        if (in_hs) begin
          k_d    = k_q + 8'd1;
          row_d  = row_step;
          col_d  = col_step;
          diag_d = diag_step;
          if (in_coeff != '0) begin
            last_sig_d = k_q;
            all_zero_d = 1'b0;
          end
          if (k_q == 8'd255) begin
            state_d = StDrain;
            r_d     = '0;
          end
        end
      end
      StDrain: begin
        if (out_hs) begin
          r_d = r_q + 8'd1;
          if (r_q == 8'd255) begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      scan_q     <= ScanDiag;
      k_q        <= '0;
      r_q        <= '0;
      row_q      <= '0;
      col_q      <= '0;
      diag_q     <= '0;
      last_sig_q <= '0;
      all_zero_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      scan_q     <= scan_d;
      k_q        <= k_d;
      r_q        <= r_d;
      row_q      <= row_d;
      col_q      <= col_d;
      diag_q     <= diag_d;
      last_sig_q <= last_sig_d;
      all_zero_q <= all_zero_d;
    end
  end

  // Coefficient store is deliberately left out of reset
  always_ff @(posedge clk) begin
    if (in_hs) begin
      mem_q[wr_addr] <= in_coeff;
    end
  end

  assign in_ready      = (state_q == StLoad);
  assign out_valid     = (state_q == StDrain);
  assign busy          = (state_q != StIdle);
  assign out_coeff     = mem_q[r_q];
  assign out_pos       = r_q;
  assign out_last      = out_valid & (r_q == 8'd255);
  assign last_sig_scan = last_sig_q;
  assign all_zero      = all_zero_q;

endmodule

// File: tb/tb_coeff_inverse_scan.sv
// Randomized self-checking bench for coeff_inverse_scan against a scan-table reference model.
module tb_coeff_inverse_scan;

  localparam int unsigned W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [1:0]   scan_type;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_coeff;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_coeff;
  logic [7:0]   out_pos;
  logic         out_last;
  logic         busy;
  logic [7:0]   last_sig_scan;
  logic         all_zero;

  int checks = 0;
  int errors = 0;
  int diag_tab [256];

  coeff_inverse_scan #(.COEFF_W(W)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .scan_type     (scan_type),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_coeff      (in_coeff),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_coeff     (out_coeff),
    .out_pos       (out_pos),
    .out_last      (out_last),
    .busy          (busy),
    .last_sig_scan (last_sig_scan),
    .all_zero      (all_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Anti-diagonal order straight from the geometric definition
  task automatic build_diag();
    int idx = 0;
    for (int s = 0; s <= 30; s++) begin
      int lo = (s > 15) ? s - 15 : 0;
      int hi = (s < 15) ? s : 15;
      if (s % 2 == 0) begin
        for (int a = hi; a >= lo; a--) begin
          diag_tab[idx] = 16 * a + (s - a);
          idx++;
        end
      end else begin
        for (int a = lo; a <= hi; a++) begin
          diag_tab[idx] = 16 * a + (s - a);
          idx++;
        end
      end
    end
  endtask

  function automatic int scan_map(input int st, input int k);
    if (st == 1) return k;
    if (st == 2) return (k % 16) * 16 + (k / 16);
    return diag_tab[k];
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 32'(0));
    check({tag, "_out_valid"}, 32'(out_valid), 32'(0));
    check({tag, "_out_last"}, 32'(out_last), 32'(0));
    check({tag, "_busy"}, 32'(busy), 32'(0));
  endtask

  // pat: 0 k+1, 1 k, 2 random, 3 only k=10 nonzero, 4 all zero
  task automatic run_block(input int st, input int pat, input int gap, input int stall);
    logic [W-1:0] data [256];
    logic [W-1:0] exp_out [256];
    int exp_last;
    int exp_zero;
    int k;
    int r;
    int n;
    logic hs;
    logic prev_stall;
    logic [W-1:0] prev_coeff;

    exp_last = 0;
    exp_zero = 1;
    for (int i = 0; i < 256; i++) begin
      case (pat)
        0: data[i] = W'(i + 1);
        1: data[i] = W'(i);
        2: data[i] = ($urandom_range(0, 3) == 0) ? '0 : W'($urandom);
        3: data[i] = (i == 10) ? W'(16'h8001) : '0;
        default: data[i] = '0;
      endcase
    end
    for (int i = 0; i < 256; i++) begin
      exp_out[scan_map(st, i)] = data[i];
      if (data[i] != '0) begin
        exp_last = i;
        exp_zero = 0;
      end
    end

    @(negedge clk);
    start = 1'b1;
    scan_type = 2'(st);
    @(negedge clk);
    start = 1'b0;
    check("load_in_ready", 32'(in_ready), 32'(1));
    check("load_busy", 32'(busy), 32'(1));
    check("load_out_valid", 32'(out_valid), 32'(0));

    k = 0;
    n = 0;
    while (k < 256 && n < 4000) begin
      scan_type = 2'($urandom);
      start     = ($urandom_range(0, 7) == 0);
      out_ready = 1'($urandom);
      in_valid  = ($urandom_range(0, 99) >= gap);
      in_coeff  = in_valid ? data[k] : W'($urandom);
      hs        = in_valid & in_ready;
      @(negedge clk);
      n++;
      if (hs) k++;
    end
    check("load_done", 32'(k), 32'(256));

    check("drain_in_ready", 32'(in_ready), 32'(0));
    check("last_sig_scan", 32'(last_sig_scan), 32'(exp_last));
    check("all_zero", 32'(all_zero), 32'(exp_zero));

    r = 0;
    n = 0;
    prev_stall = 1'b0;
    prev_coeff = '0;
    while (r < 256 && n < 2000) begin
      start     = 1'($urandom);
      in_valid  = 1'($urandom);
      in_coeff  = W'($urandom);
      scan_type = 2'($urandom);
      out_ready = (stall == 0) ? 1'b1 : ($urandom_range(0, 99) >= stall);
      check("out_valid", 32'(out_valid), 32'(1));
      if (out_valid) begin
        check("out_pos", 32'(out_pos), 32'(r));
        check("out_coeff", 32'(out_coeff), 32'(exp_out[r]));
        check("out_last", 32'(out_last), 32'(r == 255));
        if (prev_stall) check("hold_coeff", 32'(out_coeff), 32'(prev_coeff));
      end
      prev_stall = out_valid & ~out_ready;
      prev_coeff = out_coeff;
      hs = out_valid & out_ready;
      @(negedge clk);
      n++;
      if (hs) r++;
    end
    check("drain_done", 32'(r), 32'(256));

    start    = 1'b0;
    in_valid = 1'b0;
    check_idle_outputs("end");
    check("end_last_sig", 32'(last_sig_scan), 32'(exp_last));
    check("end_all_zero", 32'(all_zero), 32'(exp_zero));
  endtask

  task automatic reset_mid_load();
    int k = 0;
    @(negedge clk);
    start = 1'b1;
    scan_type = 2'd0;
    @(negedge clk);
    start = 1'b0;
    while (k < 100) begin
      in_valid = 1'b1;
      in_coeff = W'(k + 7);
      @(negedge clk);
      k++;
    end
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check_idle_outputs("rst_mid");
    check("rst_mid_out_pos", 32'(out_pos), 32'(0));
    check("rst_mid_last_sig", 32'(last_sig_scan), 32'(0));
    check("rst_mid_all_zero", 32'(all_zero), 32'(1));
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    scan_type = 2'd0;
    in_valid  = 1'b0;
    in_coeff  = '0;
    out_ready = 1'b0;
    build_diag();
    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
    check("reset_out_pos", 32'(out_pos), 32'(0));
    check("reset_last_sig", 32'(last_sig_scan), 32'(0));
    check("reset_all_zero", 32'(all_zero), 32'(1));
    rst = 1'b0;
    @(negedge clk);

    run_block(1, 0, 0, 0);
    run_block(2, 1, 0, 0);
    run_block(0, 1, 0, 0);
    run_block(3, 1, 30, 50);
    run_block(0, 3, 0, 0);
    run_block(1, 4, 0, 0);
    for (int i = 0; i < 6; i++) begin
      run_block(int'($urandom_range(0, 3)), 2, 50, 50);
    end
    reset_mid_load();
    run_block(0, 2, 30, 50);
    run_block(2, 2, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
